apb_mem_bridge: RTL and testbench

APB slave front end for the accelerator's word-wide memory. It sits directly upstream of the memory block and turns APB3/APB4 transfers into single-cycle memory reads and writes. It adds wait states, address range and alignment checking, and optional byte-strobe read-modify-write. The memory is a combinational-read, posedge-write array that returns 0 on its read port while its write enable is high.

---
 rtl/apb_mem_bridge.sv | 195 +++++++++++++++++++
 tb/tb_apb_mem_bridge.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_bridge.sv
// APB3/APB4 slave front end for a word-wide, combinational-read memory.
// Define APB_PSTRB_EN to honour pstrb_i with a read-modify-write path for partial strobes.
module apb_mem_bridge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = ADDR_WIDTH * ADDR_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic                    mem_we_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

`ifdef APB_PSTRB_EN
  typedef enum logic [1:0] {IDLE, EXEC, MERGE, RESP} state_e;
`else
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
`endif

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    mem_we_q, mem_we_d;
`ifdef APB_PSTRB_EN
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       strb_q, strb_d;
`else
  logic                    unused_pstrb;
  assign unused_pstrb = ^pstrb_i;
`endif

  // Byte address to word index, zero-extended to the port width.
  function automatic logic [ADDR_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a >> OFF_W;
  endfunction

  // Misaligned byte offset or word index beyond the array.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    logic             misaligned;
    logic [ADDR_WIDTH:0] idx_ext;
    misaligned = (a & ADDR_WIDTH'(STRB_W - 1)) != '0;
    idx_ext    = {1'b0, word_idx(a)};
    return misaligned || (idx_ext >= (ADDR_WIDTH + 1)'(MEM_DEPTH));
  endfunction

`ifdef APB_PSTRB_EN
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] nw,
                                                        input logic [DATA_WIDTH-1:0] old,
                                                        input logic [STRB_W-1:0]     strb);
    logic [DATA_WIDTH-1:0] m;
    m = old;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (strb[b]) m[b*8 +: 8] = nw[b*8 +: 8];
    end
    return m;
  endfunction
`endif

  // Outputs are registered, so the write strobe for a full write is decided in the setup cycle.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    prdata_d    = prdata_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
`ifdef APB_PSTRB_EN
    wdata_d     = wdata_q;
    strb_d      = strb_q;
`endif
    case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          addr_d     = paddr_i;
          write_d    = pwrite_i;
          mem_addr_d = word_idx(paddr_i);
          state_d    = EXEC;
`ifdef APB_PSTRB_EN
          wdata_d    = pwdata_i;
          strb_d     = pstrb_i;
          if (pwrite_i && !addr_err(paddr_i) && (&pstrb_i)) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = pwdata_i;
          end
`else
          if (pwrite_i && !addr_err(paddr_i)) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = pwdata_i;
          end
`endif
        end
      end
      EXEC: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else begin
          state_d  = RESP;
          pready_d = 1'b1;
          if (addr_err(addr_q)) begin
            pslverr_d = 1'b1;
          end else if (!write_q) begin
            prdata_d = mem_rdata_i;
          end
`ifdef APB_PSTRB_EN
          else if ((strb_q != '0) && !(&strb_q)) begin
            // mem_wdata_q doubles as the merge register for the write-back cycle.
            mem_wdata_d = merge_bytes(wdata_q, mem_rdata_i, strb_q);
            mem_we_d    = 1'b1;
            pready_d    = 1'b0;
            state_d     = MERGE;
          end
`endif
        end
      end
`ifdef APB_PSTRB_EN
      MERGE: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else begin
          state_d  = RESP;
          pready_d = 1'b1;
        end
      end
`endif
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
`ifdef APB_PSTRB_EN
      wdata_q     <= '0;
      strb_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
`ifdef APB_PSTRB_EN
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
`endif
    end
  end

  assign prdata_o    = prdata_q;
  assign pready_o    = pready_q;
  assign pslverr_o   = pslverr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Scoreboard bench for apb_mem_bridge with a behavioural memory; works with or without APB_PSTRB_EN.
module tb_apb_mem_bridge;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;

`ifdef APB_PSTRB_EN
  localparam logic [31:0] P_DATA = 32'h11BB33DD;
  localparam int          P_LAT  = 3;
  localparam int          P_WLAT = 2;
  localparam logic        Z_W    = 1'b0;
  localparam logic [31:0] W20    = 32'h11BB33DD;
  localparam logic [31:0] W20_DROP = 32'h11BB33DD;
`else
  localparam logic [31:0] P_DATA = 32'hAABBCCDD;
  localparam int          P_LAT  = 2;
  localparam int          P_WLAT = 1;
  localparam logic        Z_W    = 1'b1;
  localparam logic [31:0] W20    = 32'h55667788;
  localparam logic [31:0] W20_DROP = 32'h99999999;
`endif

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic [DW-1:0] prdata_o;
  logic          pready_o, pslverr_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_we_o;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [DEPTH];

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   t_setup = 0;
  logic [31:0] last_rd = 32'h0;

  apb_mem_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(prdata_o),
    .pready_o(pready_o), .pslverr_o(pslverr_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational read that returns 0 while writing, posedge write.
  assign mem_rdata = (mem_we_o || mem_addr_o >= 32'(DEPTH)) ? 32'h0 : mem[mem_addr_o[9:0]];
  always @(posedge clk) begin
    if (mem_we_o && mem_addr_o < 32'(DEPTH)) mem[mem_addr_o[9:0]] <= mem_wdata_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops expected responses and memory writes as the DUT presents them.
  always @(negedge clk) begin
    rsp_t r;
    wr_t  w;
    if (psel && !penable) t_setup = cyc;
    if (rst_n && pready_o) begin
      if (rsp_q.size() == 0) check("unexpected_pready", 32'(pready_o), 32'h0);
      else begin
        r = rsp_q.pop_front();
        check("pslverr", 32'(pslverr_o), 32'(r.err));
        check("prdata", prdata_o, r.rdata);
        check("rsp_latency", 32'(cyc - t_setup), 32'(r.lat));
      end
    end
    if (rst_n && mem_we_o) begin
      if (wr_q.size() == 0) check("unexpected_mem_we", 32'(mem_we_o), 32'h0);
      else begin
        w = wr_q.pop_front();
        check("mem_addr", mem_addr_o, w.addr);
        check("mem_wdata", mem_wdata_o, w.data);
        check("we_latency", 32'(cyc - t_setup), 32'(w.lat));
      end
    end
  end

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic err, input logic [31:0] prd,
                      input int lat, input logic do_w, input logic [31:0] mw, input int wlat);
    logic got;
    rsp_q.push_back('{err, prd, lat});
    if (do_w) wr_q.push_back('{addr >> 2, mw, wlat});
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = pready_o;
    end
    if (!got) check("pready_timeout", 32'(got), 32'h1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    #12;
    check("rst_prdata", prdata_o, 32'h0);
    check("rst_pready", 32'(pready_o), 32'h0);
    check("rst_pslverr", 32'(pslverr_o), 32'h0);
    check("rst_mem_we", 32'(mem_we_o), 32'h0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_wdata", mem_wdata_o, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Basic write then read.
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, last_rd, 2, 1'b1, 32'hDEADBEEF, 1);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 2, 1'b0, 32'h0, 0);
    last_rd = 32'hDEADBEEF;
    idle();
    check("mem_word4", mem[4], 32'hDEADBEEF);

    // Error responses: misaligned, out of range, and an out-of-range write.
    xfer(1'b0, 32'h1002, 32'h0, 4'hF, 1'b1, last_rd, 2, 1'b0, 32'h0, 0);
    xfer(1'b0, 32'(4 * DEPTH), 32'h0, 4'hF, 1'b1, last_rd, 2, 1'b0, 32'h0, 0);
    xfer(1'b1, 32'(4 * DEPTH), 32'h12121212, 4'hF, 1'b1, last_rd, 2, 1'b0, 32'h0, 0);
    idle();

    // Strobed writes.
    xfer(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, last_rd, 2, 1'b1, 32'h11223344, 1);
    xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, last_rd, P_LAT, 1'b1, P_DATA, P_WLAT);
    xfer(1'b1, 32'h20, 32'h55667788, 4'b0000, 1'b0, last_rd, 2, Z_W, 32'h55667788, 1);
    xfer(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, W20, 2, 1'b0, 32'h0, 0);
    last_rd = W20;
    idle();
    check("mem_word8", mem[8], W20);

    // Back-to-back write, read, write.
    xfer(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 1'b0, last_rd, 2, 1'b1, 32'hCAFEF00D, 1);
    xfer(1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D, 2, 1'b0, 32'h0, 0);
    xfer(1'b1, 32'h34, 32'h12345678, 4'hF, 1'b0, 32'hCAFEF00D, 2, 1'b1, 32'h12345678, 1);
    last_rd = 32'hCAFEF00D;
    idle();
    check("mem_word13", mem[13], 32'h12345678);

    // Access phase without setup must be ignored.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h34; pwdata = 32'h0BAD0BAD; pstrb = 4'hF;
    repeat (3) @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
    check("mem_word13_kept", mem[13], 32'h12345678);

    // Reset in the middle of a write (MERGE with strobes, EXEC otherwise).
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hFFFFFFFF; pstrb = 4'b0011;
    @(posedge clk); #1;
    penable = 1'b1;
`ifdef APB_PSTRB_EN
    @(posedge clk); #1;
`else
    pstrb = 4'b0011;
`endif
    check("we_before_reset", 32'(mem_we_o), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("we_on_reset", 32'(mem_we_o), 32'h0);
    check("prdata_on_reset", prdata_o, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    last_rd = 32'h0;
    @(posedge clk); #1;
    check("mem_word8_after_reset", mem[8], W20);
    xfer(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, W20, 2, 1'b0, 32'h0, 0);
    last_rd = W20;
    idle();

    // psel dropped during EXEC of a partial write.
    if (P_WLAT == 1) wr_q.push_back('{32'h8, 32'h99999999, 1});
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h99999999; pstrb = 4'b0101;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 psel = 1'b0; penable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mem_word8_after_drop", mem[8], W20_DROP);
    xfer(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, W20_DROP, 2, 1'b0, 32'h0, 0);
    idle();
    repeat (3) @(posedge clk);

    check("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
    check("wr_queue_drained", 32'(wr_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
